board_input_conditioner: RTL and testbench

- Upstream stage between the iCEBreaker board pins and the tt_um_rejunity_atari2600 core, clocked in the 25.125 MHz pixel domain.
- Synchronises and debounces the raw user buttons. Produces debounced levels plus one-cycle press/release pulses for the core's ui_in mapping.
- Generates the core's rst_n from PLL lock and the debounced reset button, with a stretched, synchronously deasserted release.
- Also provides a heartbeat LED toggle.

---
 rtl/board_input_conditioner.sv | 157 +++++++++++++++
 tb/tb_board_input_conditioner.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/board_input_conditioner.sv
// rtl/board_input_conditioner.sv - button conditioning, core reset generation and heartbeat
//
// Purpose: sits between the board pins and the game core in the pixel clock
// domain. Synchronises and debounces the user buttons, produces one-cycle
// press/release pulses, builds the core reset from PLL lock and the reset
// button, and toggles a heartbeat LED.
//
// Ports:
//   clk            pixel clock from the PLL
//   rst_n          asynchronous active-low reset for the whole block
//   pll_locked     PLL lock, asynchronous to clk
//   btn_raw        raw active-high user buttons, asynchronous
//   btn_rst_n_raw  raw active-low reset button, asynchronous
//   btn_level      debounced button levels
//   btn_press      one-cycle pulse when a btn_level bit rises
//   btn_release    one-cycle pulse when a btn_level bit falls
//   core_rst_n     active-low core reset, released synchronously
//   heartbeat      LED toggle, runs only while the core is out of reset
module board_input_conditioner #(
  parameter int NUM_BTN          = 3,
  parameter int DEB_CYCLES       = 250000,
  parameter int RST_HOLD         = 1024,
  parameter int HEARTBEAT_CYCLES = 12600000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_locked,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic               btn_rst_n_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               core_rst_n,
  output logic               heartbeat
);

  // Channel NUM_BTN is the (inverted) reset button; lower channels are buttons.
  localparam int NCH = NUM_BTN + 1;
  localparam int DW  = $clog2(DEB_CYCLES);
  localparam int HW  = $clog2(RST_HOLD);
  localparam int BW  = $clog2(HEARTBEAT_CYCLES);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);
  localparam logic [BW-1:0] HB_LAST   = BW'(HEARTBEAT_CYCLES - 1);

  logic [NCH-1:0] raw_all;
  logic [NCH-1:0] sync1;
  logic [NCH-1:0] sync2;
  logic           lock_s1;
  logic           lock_s2;
  logic [NCH-1:0] level;
  logic [NUM_BTN-1:0] accept;

  // Reset button is inverted ahead of its synchroniser so idle reads as 0.
  assign raw_all = {~btn_rst_n_raw, btn_raw};

  // Two-flop synchronisers with nothing between the stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      lock_s1 <= 1'b0;
      lock_s2 <= 1'b0;
    end else begin
      sync1   <= raw_all;
      sync2   <= sync1;
      lock_s1 <= pll_locked;
      lock_s2 <= lock_s1;
    end
  end

  // One debouncer per channel: a level change is accepted only after the
  // synchronised input has disagreed with the stable level for DEB_CYCLES
  // consecutive edges; any agreement restarts the count.
  for (genvar i = 0; i < NCH; i++) begin : g_deb
    logic [DW-1:0] cnt;
    logic          lvl;
    logic          hit;

    assign hit      = (sync2[i] != lvl) && (cnt == DEB_LAST);
    assign level[i] = lvl;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (sync2[i] == lvl) begin
        cnt <= '0;
      end else if (hit) begin
        lvl <= sync2[i];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    if (i < NUM_BTN) begin : g_acc
      assign accept[i] = hit;
    end
  end

  assign btn_level = level[NUM_BTN-1:0];

  // Pulses are registered on the same edge the stable level changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_press   <= '0;
      btn_release <= '0;
    end else begin
      btn_press   <= accept & sync2[NUM_BTN-1:0];
      btn_release <= accept & ~sync2[NUM_BTN-1:0];
    end
  end

  // Core reset: any cause clears the count and asserts reset on the next
  // edge; release needs RST_HOLD consecutive cause-free edges.
  logic          hold;
  logic [HW-1:0] hcnt;

  assign hold = ~lock_s2 | level[NUM_BTN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt       <= '0;
      core_rst_n <= 1'b0;
    end else if (hold) begin
      hcnt       <= '0;
      core_rst_n <= 1'b0;
    end else if (!core_rst_n) begin
      if (hcnt == HOLD_LAST) begin
        core_rst_n <= 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  // Heartbeat counter is parked at zero while the core is in reset; the LED
  // keeps whatever value it had.
  logic [BW-1:0] hb_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_cnt    <= '0;
      heartbeat <= 1'b0;
    end else if (!core_rst_n) begin
      hb_cnt <= '0;
    end else if (hb_cnt == HB_LAST) begin
      hb_cnt    <= '0;
      heartbeat <= ~heartbeat;
    end else begin
      hb_cnt <= hb_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_board_input_conditioner.sv
// tb/tb_board_input_conditioner.sv - directed bench with pulse scoreboard for board_input_conditioner
module tb_board_input_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic [2:0] btn_raw;
  logic       btn_rst_n_raw;
  logic [2:0] btn_level;
  logic [2:0] btn_press;
  logic [2:0] btn_release;
  logic       core_rst_n;
  logic       heartbeat;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         at;
    logic [2:0] p;
    logic [2:0] r;
  } ev_t;

  ev_t sb[$];

  board_input_conditioner #(
    .NUM_BTN         (3),
    .DEB_CYCLES      (4),
    .RST_HOLD        (8),
    .HEARTBEAT_CYCLES(10)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .btn_raw      (btn_raw),
    .btn_rst_n_raw(btn_rst_n_raw),
    .btn_level    (btn_level),
    .btn_press    (btn_press),
    .btn_release  (btn_release),
    .core_rst_n   (core_rst_n),
    .heartbeat    (heartbeat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic wait_edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge right after driving a button change: the pulse is
  // due on the 6th following edge (2 sync + 4 debounce).
  task automatic expect_pulse(input logic [2:0] p, input logic [2:0] r);
    ev_t e;
    e.at = cyc + 6;
    e.p  = p;
    e.r  = r;
    sb.push_back(e);
  endtask

  // Pulse monitor: every non-zero pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (btn_press !== 3'b000 || btn_release !== 3'b000)) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_pulse: observed press=%b release=%b at cycle %0d expected none",
               btn_press, btn_release, cyc);
      end
      if (sb.size() > 0) begin
        ev_t e;
        e = sb.pop_front();
        checks++;
        assert ({cyc, btn_press, btn_release} === {e.at, e.p, e.r}) else begin
          errors++;
          $error("FAIL pulse: observed cycle %0d press=%b release=%b expected cycle %0d press=%b release=%b",
                 cyc, btn_press, btn_release, e.at, e.p, e.r);
        end
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    pll_locked    = 1'b0;
    btn_raw       = 3'b000;
    btn_rst_n_raw = 1'b1;
    wait_edges(3);
    chk("rst_level",   btn_level,   0);
    chk("rst_press",   btn_press,   0);
    chk("rst_release", btn_release, 0);
    chk("rst_core",    core_rst_n,  0);
    chk("rst_hb",      heartbeat,   0);

    // Power-up: core reset releases on the 10th edge after lock.
    rst_n      = 1'b1;
    pll_locked = 1'b1;
    wait_edges(9);
    chk("pwr_core_before", core_rst_n, 0);
    wait_edges(1);
    chk("pwr_core_after", core_rst_n, 1);

    // Heartbeat toggles every 10 edges once the core runs.
    wait_edges(9);
    chk("hb_before_1", heartbeat, 0);
    wait_edges(1);
    chk("hb_toggle_1", heartbeat, 1);
    wait_edges(9);
    chk("hb_before_2", heartbeat, 1);
    wait_edges(1);
    chk("hb_toggle_2", heartbeat, 0);

    // Lock loss drops core reset 3 edges later; heartbeat is frozen.
    pll_locked = 1'b0;
    wait_edges(2);
    chk("lock_loss_before", core_rst_n, 1);
    wait_edges(1);
    chk("lock_loss_after", core_rst_n, 0);
    wait_edges(15);
    chk("hb_frozen", heartbeat, 0);
    pll_locked = 1'b1;
    wait_edges(9);
    chk("relock_before", core_rst_n, 0);
    wait_edges(1);
    chk("relock_after", core_rst_n, 1);

    // Debounced press and release of button 0.
    btn_raw = 3'b001;
    expect_pulse(3'b001, 3'b000);
    wait_edges(5);
    chk("b0_level_before", btn_level, 3'b000);
    wait_edges(1);
    chk("b0_level_after", btn_level, 3'b001);
    wait_edges(1);
    chk("b0_press_one_cycle", btn_press, 3'b000);
    btn_raw = 3'b000;
    expect_pulse(3'b000, 3'b001);
    wait_edges(6);
    chk("b0_release_level", btn_level, 3'b000);

    // Glitch rejection: 3 cycles high is too short.
    btn_raw = 3'b010;
    wait_edges(3);
    btn_raw = 3'b000;
    wait_edges(10);
    chk("b1_glitch_level", btn_level, 3'b000);

    // Bounce 1,0,1 then stable: accepted 6 edges after the last transition.
    btn_raw = 3'b010;
    wait_edges(1);
    btn_raw = 3'b000;
    wait_edges(1);
    btn_raw = 3'b010;
    expect_pulse(3'b010, 3'b000);
    wait_edges(5);
    chk("b1_bounce_before", btn_level, 3'b000);
    wait_edges(1);
    chk("b1_bounce_after", btn_level, 3'b010);
    btn_raw = 3'b000;
    expect_pulse(3'b000, 3'b010);
    wait_edges(6);
    chk("b1_release_level", btn_level, 3'b000);

    // Simultaneous buttons, then release of bit 2 alone.
    btn_raw = 3'b111;
    expect_pulse(3'b111, 3'b000);
    wait_edges(6);
    chk("all_level", btn_level, 3'b111);
    btn_raw = 3'b011;
    expect_pulse(3'b000, 3'b100);
    wait_edges(6);
    chk("b2_release_level", btn_level, 3'b011);
    btn_raw = 3'b000;
    expect_pulse(3'b000, 3'b011);
    wait_edges(6);
    chk("all_release_level", btn_level, 3'b000);

    // Reset button held 10 cycles: core falls after 7 edges, returns 14 after release.
    btn_rst_n_raw = 1'b0;
    wait_edges(6);
    chk("rbtn_core_before", core_rst_n, 1);
    wait_edges(1);
    chk("rbtn_core_after", core_rst_n, 0);
    wait_edges(3);
    btn_rst_n_raw = 1'b1;
    wait_edges(13);
    chk("rbtn_rel_before", core_rst_n, 0);
    wait_edges(1);
    chk("rbtn_rel_after", core_rst_n, 1);

    // Re-press during the hold count restarts it.
    btn_rst_n_raw = 1'b0;
    wait_edges(7);
    chk("rbtn2_core_low", core_rst_n, 0);
    wait_edges(1);
    btn_rst_n_raw = 1'b1;      // R
    wait_edges(5);
    btn_rst_n_raw = 1'b0;      // R+5
    wait_edges(8);
    btn_rst_n_raw = 1'b1;      // R+13
    wait_edges(1);
    chk("restart_r14", core_rst_n, 0);
    wait_edges(8);
    chk("restart_r22", core_rst_n, 0);
    wait_edges(4);
    chk("restart_r26", core_rst_n, 0);
    wait_edges(1);
    chk("restart_r27", core_rst_n, 1);

    // Reset asserted mid-debounce: outputs clear at once, no pulse follows.
    btn_raw = 3'b001;
    wait_edges(3);
    rst_n = 1'b0;
    #1;
    chk("midrst_level",   btn_level,   0);
    chk("midrst_press",   btn_press,   0);
    chk("midrst_release", btn_release, 0);
    chk("midrst_core",    core_rst_n,  0);
    chk("midrst_hb",      heartbeat,   0);
    wait_edges(1);
    btn_raw = 3'b000;
    rst_n   = 1'b1;
    wait_edges(12);
    chk("midrst_level_after", btn_level, 0);

    chk("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
